next_piece_gen: RTL and testbench

- Consumes the 8-bit pseudo-random byte from the Tetris LFSR and turns it into tetromino type codes 0..6.
- Holds a current piece and a one-deep preview (next) piece for the game FSM.
- Drives the LFSR `new_block` advance strobe itself.
- Rejects invalid codes and, within a bounded re-roll budget, immediate repeats.

---
 rtl/next_piece_gen.sv | 123 ++++++++++++
 tb/tb_next_piece_gen.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_piece_gen.sv
// rtl/next_piece_gen.sv - tetromino picker with preview slot, LFSR advance strobe and bounded re-roll
// Every sample cycle pulses new_block; WAIT lets the advanced LFSR byte settle before the next look.
module next_piece_gen #(
    parameter int MAX_REROLL = 2,
    parameter bit NO_REPEAT  = 1'b1
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic [7:0]  rand_in,
    input  logic        req,
    output logic        new_block,
    output logic        piece_valid,
    output logic [2:0]  cur_piece,
    output logic [2:0]  next_piece,
    output logic [15:0] piece_count
);

    localparam int CW = (MAX_REROLL < 1) ? 1 : $clog2(MAX_REROLL + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_REROLL);

    typedef enum logic [2:0] {
        FILL_CUR  = 3'd0,
        FILL_NEXT = 3'd1,
        SAMPLE    = 3'd2,
        WAIT      = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t          r_state;
    state_t          r_ret;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_cur;
    logic [2:0]      r_next;
    logic [15:0]     r_count;

    state_t          w_state_nxt;
    state_t          w_ret_nxt;
    logic            w_nb;
    logic            w_accept;
    logic            w_reject;
    logic            w_take;
    logic [2:0]      w_c;
    logic [2:0]      w_pick;
    logic            w_bad;
    logic            w_budget;
    logic            w_unused_rand;

    assign w_c           = rand_in[2:0];
    assign w_unused_rand = ^rand_in[7:3];
    assign w_budget      = (r_cnt < MAX_CNT);
    // Repeat rule only applies when refilling the preview after a hand-out.
    assign w_bad         = (w_c == 3'd7) || (NO_REPEAT && (r_state == SAMPLE) && (w_c == r_cur));
    assign w_pick        = (w_c == 3'd7) ? 3'd0 : w_c;

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_nb        = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            FILL_CUR, FILL_NEXT, SAMPLE: begin
                w_nb        = 1'b1;
                w_state_nxt = WAIT;
                if (w_bad && w_budget) begin
                    w_reject  = 1'b1;
                    w_ret_nxt = r_state;
                end else begin
                    w_accept  = 1'b1;
                    w_ret_nxt = (r_state == FILL_CUR) ? FILL_NEXT : READY;
                end
            end
            WAIT: begin
                w_state_nxt = r_ret;
            end
            READY: begin
                if (req) begin
                    w_state_nxt = SAMPLE;
                    w_take      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FILL_CUR;
            end
        endcase
    end

    always_ff @(posedge vclk) begin
        if (rst) begin
            r_state <= FILL_CUR;
            r_ret   <= FILL_CUR;
            r_cnt   <= '0;
            r_cur   <= 3'd0;
            r_next  <= 3'd0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            if (w_reject) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_accept) begin
                r_cnt <= '0;
            end
            if (w_accept && (r_state == FILL_CUR)) begin
                r_cur <= w_pick;
            end else if (w_accept) begin
                r_next <= w_pick;
            end
            if (w_take) begin
                r_cur   <= r_next;
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign new_block   = w_nb & ~rst;
    assign piece_valid = (r_state == READY);
    assign cur_piece   = r_cur;
    assign next_piece  = r_next;
    assign piece_count = r_count;

endmodule

// File: tb/tb_next_piece_gen.sv
// tb/tb_next_piece_gen.sv - bench for next_piece_gen with a scripted LFSR and a sample-rule reference model
module tb_next_piece_gen;

    localparam int MAX_REROLL = 2;

    logic        vclk = 1'b0;
    always #5 vclk = ~vclk;

    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  rand_in;
    logic        new_block, piece_valid;
    logic [2:0]  cur_piece, next_piece;
    logic [15:0] piece_count;

    logic        rst0 = 1'b1;
    logic        req0 = 1'b0;
    logic [7:0]  rand0;
    logic        nb0, valid0;
    logic [2:0]  cur0, next0;
    logic [15:0] count0;

    int checks = 0;
    int errors = 0;

    logic [7:0] script [0:4095];
    int         idx = 0;
    int         pulses = 0;
    logic [7:0] script0 [0:15];
    int         idx0 = 0;

    logic [2:0]  m_cur, m_next;
    logic [15:0] m_count;

    assign rand_in = script[idx[11:0]];
    assign rand0   = script0[idx0[3:0]];

    next_piece_gen #(.MAX_REROLL(MAX_REROLL), .NO_REPEAT(1'b1)) dut (
        .vclk(vclk), .rst(rst), .rand_in(rand_in), .req(req), .new_block(new_block),
        .piece_valid(piece_valid), .cur_piece(cur_piece), .next_piece(next_piece), .piece_count(piece_count)
    );

    next_piece_gen #(.MAX_REROLL(MAX_REROLL), .NO_REPEAT(1'b0)) dut0 (
        .vclk(vclk), .rst(rst0), .rand_in(rand0), .req(req0), .new_block(nb0),
        .piece_valid(valid0), .cur_piece(cur0), .next_piece(next0), .piece_count(count0)
    );

    // LFSR stand-ins: each advances only when its DUT strobes new_block.
    always @(posedge vclk) begin
        if (new_block) begin
            idx    <= idx + 1;
            pulses <= pulses + 1;
        end
        if (nb0) idx0 <= idx0 + 1;
    end

    always @(negedge vclk) begin
        if (piece_valid) begin
            checks++;
            if (new_block !== 1'b0) begin
                errors++;
                $display("FAIL nb_in_ready: new_block=%0b required 0", new_block);
            end
        end
    end

    function automatic void predict(input int start, input logic [2:0] cur, input bit rep,
                                    output logic [2:0] pick, output int rej);
        logic [2:0] c;
        pick = 3'd0;
        rej  = 0;
        for (int k = 0; k <= MAX_REROLL; k++) begin
            c = script[12'(start + k)][2:0];
            if (k == MAX_REROLL) begin
                pick = (c == 3'd7) ? 3'd0 : c;
                rej  = k;
                break;
            end
            if (c != 3'd7 && !(rep && c == cur)) begin
                pick = c;
                rej  = k;
                break;
            end
        end
    endfunction

    task automatic set_s(input int k, input logic [7:0] v);
        script[12'(idx + k)] = v;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge vclk);
            cyc++;
        end while (!piece_valid && cyc < 50);
    endtask

    task automatic reset_fill(input string nm, input int ecyc, input logic [2:0] ec,
                              input logic [2:0] en, input int ep);
        int cyc, p0;
        @(negedge vclk);
        rst = 1'b1;
        req = 1'b0;
        @(negedge vclk);
        rst = 1'b0;
        p0  = pulses;
        wait_valid(cyc);
        checks++;
        if (piece_valid !== 1'b1) begin errors++; $display("FAIL %s_timeout: piece_valid=%0b required 1", nm, piece_valid); end
        checks++;
        if (cyc !== ecyc) begin errors++; $display("FAIL %s_latency: cycles=%0d required %0d", nm, cyc, ecyc); end
        checks++;
        if (cur_piece !== ec) begin errors++; $display("FAIL %s_cur: got %0d required %0d", nm, cur_piece, ec); end
        checks++;
        if (next_piece !== en) begin errors++; $display("FAIL %s_next: got %0d required %0d", nm, next_piece, en); end
        checks++;
        if (pulses - p0 !== ep) begin errors++; $display("FAIL %s_pulses: got %0d required %0d", nm, pulses - p0, ep); end
        checks++;
        if (piece_count !== 16'd0) begin errors++; $display("FAIL %s_count: got %0d required 0", nm, piece_count); end
        m_cur   = ec;
        m_next  = en;
        m_count = 16'd0;
    endtask

    task automatic req_check(input string nm, input logic [2:0] en, input int er, input bit hold);
        int cyc, p0;
        logic [2:0] ec;
        ec  = m_next;
        p0  = pulses;
        req = 1'b1;
        @(negedge vclk);
        if (!hold) req = 1'b0;
        checks++;
        if (piece_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_drop: got %0b required 0", nm, piece_valid); end
        checks++;
        if (cur_piece !== ec) begin errors++; $display("FAIL %s_cur_shift: got %0d required %0d", nm, cur_piece, ec); end
        checks++;
        if (piece_count !== 16'(m_count + 16'd1)) begin errors++; $display("FAIL %s_count: got %0d required %0d", nm, piece_count, 16'(m_count + 16'd1)); end
        wait_valid(cyc);
        cyc++;
        checks++;
        if (cyc !== 3 + 2 * er) begin errors++; $display("FAIL %s_latency: cycles=%0d required %0d", nm, cyc, 3 + 2 * er); end
        checks++;
        if (next_piece !== en) begin errors++; $display("FAIL %s_next: got %0d required %0d", nm, next_piece, en); end
        checks++;
        if (cur_piece !== ec) begin errors++; $display("FAIL %s_cur_hold: got %0d required %0d", nm, cur_piece, ec); end
        checks++;
        if (pulses - p0 !== er + 1) begin errors++; $display("FAIL %s_pulses: got %0d required %0d", nm, pulses - p0, er + 1); end
        m_cur   = ec;
        m_next  = en;
        m_count = 16'(m_count + 16'd1);
    endtask

    task automatic test_reset;
        @(negedge vclk);
        rst = 1'b1;
        @(negedge vclk);
        checks++;
        if ({new_block, piece_valid, cur_piece, next_piece, piece_count} !== 24'd0) begin
            errors++;
            $display("FAIL reset_values: nb=%0b valid=%0b cur=%0d next=%0d count=%0d required all 0",
                     new_block, piece_valid, cur_piece, next_piece, piece_count);
        end
        set_s(0, 8'h03);
        set_s(1, 8'h05);
        reset_fill("reset_fill", 4, 3'd3, 3'd5, 2);
    endtask

    task automatic test_reject7;
        set_s(0, 8'h07);
        set_s(1, 8'h02);
        set_s(2, 8'h04);
        reset_fill("reject7", 6, 3'd2, 3'd4, 3);
    endtask

    task automatic test_repeat;
        set_s(0, 8'h04);
        set_s(1, 8'h01);
        req_check("repeat", 3'd1, 1, 1'b0);
    endtask

    task automatic test_budget;
        set_s(0, 8'h07);
        set_s(1, 8'h07);
        set_s(2, 8'h07);
        req_check("budget", 3'd0, 2, 1'b0);
        set_s(0, 8'h07);
        set_s(1, 8'h03);
        req_check("budget_clear", 3'd3, 1, 1'b0);
    endtask

    task automatic test_repeat_off;
        int cyc;
        script0[4'(idx0)]     = 8'h02;
        script0[4'(idx0 + 1)] = 8'h04;
        script0[4'(idx0 + 2)] = 8'h04;
        script0[4'(idx0 + 3)] = 8'h01;
        @(negedge vclk);
        rst0 = 1'b0;
        cyc  = 0;
        do begin @(negedge vclk); cyc++; end while (!valid0 && cyc < 50);
        checks++;
        if ({cur0, next0} !== {3'd2, 3'd4}) begin errors++; $display("FAIL norep_fill: cur=%0d next=%0d required 2 4", cur0, next0); end
        req0 = 1'b1;
        @(negedge vclk);
        req0 = 1'b0;
        cyc  = 0;
        do begin @(negedge vclk); cyc++; end while (!valid0 && cyc < 50);
        checks++;
        if ({valid0, cur0, next0} !== {1'b1, 3'd4, 3'd4}) begin
            errors++;
            $display("FAIL norep_next: valid=%0b cur=%0d next=%0d required 1 4 4", valid0, cur0, next0);
        end
        checks++;
        if (count0 !== 16'd1) begin errors++; $display("FAIL norep_count: got %0d required 1", count0); end
    endtask

    task automatic test_busy;
        logic [2:0] v, ec;
        int cyc;
        v  = (m_next == 3'd6) ? 3'd0 : m_next + 3'd1;
        ec = m_next;
        set_s(0, 8'h07);
        set_s(1, {5'h1A, v});
        req = 1'b1;
        @(negedge vclk);
        req = 1'b0;
        @(negedge vclk);
        req = 1'b1;
        @(negedge vclk);
        @(negedge vclk);
        req = 1'b0;
        checks++;
        if ({cur_piece, piece_count} !== {ec, 16'(m_count + 16'd1)}) begin
            errors++;
            $display("FAIL busy_ignore: cur=%0d count=%0d required %0d %0d", cur_piece, piece_count, ec, 16'(m_count + 16'd1));
        end
        wait_valid(cyc);
        checks++;
        if ({piece_valid, cur_piece, next_piece, piece_count} !== {1'b1, ec, v, 16'(m_count + 16'd1)}) begin
            errors++;
            $display("FAIL busy_done: valid=%0b cur=%0d next=%0d count=%0d required 1 %0d %0d %0d",
                     piece_valid, cur_piece, next_piece, piece_count, ec, v, 16'(m_count + 16'd1));
        end
        m_cur   = ec;
        m_next  = v;
        m_count = 16'(m_count + 16'd1);
    endtask

    task automatic test_back_to_back;
        logic [2:0] pn;
        int r;
        for (int i = 0; i < 4; i++) begin
            predict(idx, m_next, 1'b1, pn, r);
            req_check("held_req", pn, r, 1'b1);
        end
        req = 1'b0;
    endtask

    task automatic test_random;
        logic [2:0] pn;
        int r;
        for (int i = 0; i < 30; i++) begin
            predict(idx, m_next, 1'b1, pn, r);
            req_check("random", pn, r, 1'b0);
        end
    endtask

    task automatic test_reset_midroll;
        logic [2:0] p1, p2;
        int r1, r2;
        req = 1'b1;
        @(negedge vclk);
        req = 1'b0;
        @(negedge vclk);
        rst = 1'b1;
        @(negedge vclk);
        checks++;
        if ({new_block, piece_valid, cur_piece, next_piece, piece_count} !== 24'd0) begin
            errors++;
            $display("FAIL midroll_reset: nb=%0b valid=%0b cur=%0d next=%0d count=%0d required all 0",
                     new_block, piece_valid, cur_piece, next_piece, piece_count);
        end
        predict(idx, 3'd0, 1'b0, p1, r1);
        predict(idx + r1 + 1, p1, 1'b0, p2, r2);
        reset_fill("midroll_fill", 4 + 2 * (r1 + r2), p1, p2, r1 + r2 + 2);
    endtask

    task automatic test_count_wrap;
        logic [2:0] pn;
        int r;
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        m_count = 16'hFFFF;
        predict(idx, m_next, 1'b1, pn, r);
        req_check("wrap", pn, r, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) script[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) script0[i] = 8'h00;
        test_reset();
        test_reject7();
        test_repeat();
        test_budget();
        test_repeat_off();
        test_busy();
        test_back_to_back();
        test_random();
        test_reset_midroll();
        test_random();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
